mux5_collector: RTL and testbench
=================================

Name: mux5_collector

Overview:
- Reverse of the 1-to-5 channel router: merges five 8-bit producer channels into one 8-bit stream.
- Tags each word with its source channel index, so the downstream consumer (HPS-side bridge) can demultiplex it again.
- Round-robin arbitration, valid/ready handshakes on every port, one-word registered output stage.

Parameters:
- DATA_W, 8, width of every data bus.
- N_CH, 5, number of input channels; fixed range 2..8; channel index width is 3 bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  reset; asynchronous, active-low.
- in_valid  input  N_CH  bit i set = channel i presents a word.
- in_data0..in_data4  input  DATA_W each  channel 0..4 data.
- in_ready  output  N_CH  bit i set = channel i word accepted this cycle; one-hot or zero.
- out_valid  output  1  out_data/out_sel hold a word.
- out_data  output  DATA_W  collected word.
- out_sel  output  3  source channel of out_data, range 0..N_CH-1.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0, state EMPTY.
  - in_ready forced to all zeros while reset_n is low.
- State machine, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load condition: load_en = (state==EMPTY) or (state==FULL and out_ready).
- Grant:
  - When load_en and in_valid is nonzero, grant = first channel i with in_valid[i]=1, searching ptr, ptr+1, … with wrap N_CH-1 -> 0.
  - in_ready[grant]=1 combinationally in the same cycle. All other in_ready bits are 0.
  - Combinational paths in_valid->in_ready and out_ready->in_ready are permitted.
- On a clock edge with a grant:
  - out_data <= in_data[grant], out_sel <= grant.
  - ptr <= grant+1, with N_CH-1 wrapping to 0.
  - state <= FULL.
- On a clock edge with load_en and no in_valid bit set:
  - state <= EMPTY.
  - out_data and out_sel keep their last values.
- FULL with out_ready=0: out_data and out_sel stay stable, no grant, all in_ready=0.
- Latency and throughput:
  - An accepted input appears on out_valid/out_data on the next cycle.
  - Sustained throughput is one word per cycle while out_ready=1.
- Fairness:
  - A channel that holds in_valid is granted within N_CH accepted transfers.
  - The pointer advances only on a grant, never on idle cycles.
- Simultaneous pop and push in FULL (out_ready=1 and in_valid nonzero): the old word leaves and the new word loads on the same edge. No bubble.
- Producers must hold in_data stable while in_valid=1 and in_ready=0. The block does not check this.
- Reset asserted mid-transfer: the held word is discarded; no partial state survives.
- Channel bits at or above N_CH are ignored. out_sel never exceeds N_CH-1.

Test Plan:
- Reset, then single word: in_valid=5'b00100, in_data2=8'hA5, out_ready=1.
  - Required: in_ready=5'b00100 in the same cycle.
  - Next cycle: out_valid=1, out_data=8'hA5, out_sel=3'd2.
  - Following cycle: out_valid=0.
- All five channels valid continuously, in_dataK=8'h10+K, out_ready=1.
  - Required: out_sel sequence 0,1,2,3,4,0,… one word per cycle.
  - Required: each in_ready bit pulses once every 5 cycles.
- Backpressure: FULL with out_data=8'h3C, out_ready=0 for 4 cycles while channels 1 and 3 are valid.
  - Required: out_data stays 8'h3C and in_ready=0 throughout.
  - After out_ready rises: next word comes from the channel after the last granted one.
- Pointer wrap: last grant was channel 4; in_valid=5'b10001.
  - Required: channel 0 is granted before channel 4, so out_sel=0, then 4.
- Asynchronous reset mid-stream: drop reset_n between clock edges while FULL with out_sel=3.
  - Required: out_valid=0, out_data=0, out_sel=0 and in_ready=0 immediately.
  - After release with in_valid=5'b11111: the first grant is channel 0.
- Idle gap: FULL, out_ready=1, in_valid=0.
  - Required: state goes EMPTY, out_valid=0.
  - Required: the pointer is unchanged; the next grant resumes from the stored ptr.

Source files
------------

// File: rtl/mux5_collector_if.sv
// Handshake bundle for the five-channel collector: producer-side valid/ready/data
// lanes plus the tagged single-stream consumer side.
interface mux5_collector_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 5
);
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  logic [DATA_W-1:0] in_data0;
  logic [DATA_W-1:0] in_data1;
  logic [DATA_W-1:0] in_data2;
  logic [DATA_W-1:0] in_data3;
  logic [DATA_W-1:0] in_data4;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_sel;
  logic              out_ready;

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, in_data4, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, in_data4, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux5_collector.sv
// Round-robin collector: merges N_CH producer channels into one registered,
// source-tagged output stream with a single-word holding stage.
module mux5_collector #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  mux5_collector_if.slave   bus
);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t            state;
  logic [2:0]        ptr;
  logic              loadEn;
  logic              grant;
  logic              grantFound;
  logic [2:0]        grantIdx;
  logic [3:0]        idx;
  logic [7:0]        validPad;
  logic [7:0]        readyVec;
  logic [DATA_W-1:0] dataArr [8];

  assign validPad = 8'(bus.in_valid);
  assign loadEn   = (state == EMPTY) || bus.out_ready;
  assign grant    = reset_n && loadEn && grantFound;
  assign readyVec = 8'b1 << grantIdx;
  assign bus.in_ready  = grant ? readyVec[N_CH-1:0] : '0;
  assign bus.out_valid = (state == FULL);

  always_comb begin
    dataArr    = '{default: '0};
    dataArr[0] = bus.in_data0;
    dataArr[1] = bus.in_data1;
    dataArr[2] = bus.in_data2;
    dataArr[3] = bus.in_data3;
    dataArr[4] = bus.in_data4;
  end

  // First requesting channel at or after ptr, wrapping at N_CH.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    idx        = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(N_CH)) idx = idx - 4'(N_CH);
      if (!grantFound && validPad[idx[2:0]]) begin
        grantFound = 1'b1;
        grantIdx   = idx[2:0];
      end
    end
  end

  // The pointer only moves on a grant, so idle cycles keep fairness order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= EMPTY;
      ptr          <= '0;
      bus.out_data <= '0;
      bus.out_sel  <= '0;
    end else if (loadEn) begin
      if (grant) begin
        bus.out_data <= dataArr[grantIdx];
        bus.out_sel  <= grantIdx;
        ptr          <= (grantIdx == 3'(N_CH - 1)) ? 3'd0 : grantIdx + 3'd1;
        state        <= FULL;
      end else begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_mux5_collector.sv
// Directed-vector bench for mux5_collector: table of per-cycle stimulus with
// expected in_ready and post-edge output values, plus an async-reset sequence.
module tb_mux5_collector;

  typedef struct {
    logic [4:0] valid;
    logic [7:0] base;
    logic       outReady;
    logic [4:0] expReady;
    logic       expValid;
    logic [7:0] expData;
    logic [2:0] expSel;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  vec_t vecs[$];

  mux5_collector_if #(.DATA_W(8), .N_CH(5)) bus ();

  mux5_collector #(.DATA_W(8), .N_CH(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] valid, input logic [7:0] base,
                               input logic outReady);
    bus.in_valid  = valid;
    bus.in_data0  = base;
    bus.in_data1  = base + 8'd1;
    bus.in_data2  = base + 8'd2;
    bus.in_data3  = base + 8'd3;
    bus.in_data4  = base + 8'd4;
    bus.out_ready = outReady;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic [4:0] valid, input logic [7:0] base,
                        input logic outReady, input logic [4:0] expReady,
                        input logic expValid, input logic [7:0] expData,
                        input logic [2:0] expSel);
    vec_t v;
    v.valid = valid; v.base = base; v.outReady = outReady;
    v.expReady = expReady; v.expValid = expValid;
    v.expData = expData; v.expSel = expSel;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Single word from channel 2, then an idle cycle.
    addVec(5'b00100, 8'hA3, 1'b1, 5'b00100, 1'b1, 8'hA5, 3'd2);
    addVec(5'b00000, 8'h10, 1'b1, 5'b00000, 1'b0, 8'hA5, 3'd2);
    // All channels valid: resumes at stored ptr=3, then full rotation.
    addVec(5'b11111, 8'h10, 1'b1, 5'b01000, 1'b1, 8'h13, 3'd3);
    addVec(5'b11111, 8'h10, 1'b1, 5'b10000, 1'b1, 8'h14, 3'd4);
    addVec(5'b11111, 8'h10, 1'b1, 5'b00001, 1'b1, 8'h10, 3'd0);
    addVec(5'b11111, 8'h10, 1'b1, 5'b00010, 1'b1, 8'h11, 3'd1);
    addVec(5'b11111, 8'h10, 1'b1, 5'b00100, 1'b1, 8'h12, 3'd2);
    addVec(5'b11111, 8'h10, 1'b1, 5'b01000, 1'b1, 8'h13, 3'd3);
    addVec(5'b11111, 8'h10, 1'b1, 5'b10000, 1'b1, 8'h14, 3'd4);
    // Pointer wrap after channel 4: channel 0 before channel 4.
    addVec(5'b10001, 8'h10, 1'b1, 5'b00001, 1'b1, 8'h10, 3'd0);
    addVec(5'b10001, 8'h10, 1'b1, 5'b10000, 1'b1, 8'h14, 3'd4);
    // Backpressure holding 3C from channel 0.
    addVec(5'b00001, 8'h3C, 1'b1, 5'b00001, 1'b1, 8'h3C, 3'd0);
    for (int i = 0; i < 4; i++)
      addVec(5'b01010, 8'h10, 1'b0, 5'b00000, 1'b1, 8'h3C, 3'd0);
    addVec(5'b01010, 8'h10, 1'b1, 5'b00010, 1'b1, 8'h11, 3'd1);
    addVec(5'b01010, 8'h10, 1'b1, 5'b01000, 1'b1, 8'h13, 3'd3);
    // Idle gap from FULL, then resume from stored ptr=4.
    addVec(5'b00000, 8'h10, 1'b1, 5'b00000, 1'b0, 8'h13, 3'd3);
    addVec(5'b11111, 8'h10, 1'b1, 5'b10000, 1'b1, 8'h14, 3'd4);
    // FULL stall with nothing pending, drain, then load from EMPTY despite out_ready=0.
    addVec(5'b00000, 8'h10, 1'b0, 5'b00000, 1'b1, 8'h14, 3'd4);
    addVec(5'b00000, 8'h10, 1'b1, 5'b00000, 1'b0, 8'h14, 3'd4);
    addVec(5'b00010, 8'h10, 1'b0, 5'b00010, 1'b1, 8'h11, 3'd1);
    addVec(5'b01000, 8'h20, 1'b1, 5'b01000, 1'b1, 8'h23, 3'd3);

    // Reset with requests pending: in_ready must stay zero.
    reset_n = 1'b0;
    applyStimulus(5'b11111, 8'h10, 1'b1);
    #2;
    checkOutput("reset.inReady",  32'(bus.in_ready),  32'h0);
    checkOutput("reset.outValid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset.outData",  32'(bus.out_data),  32'h0);
    checkOutput("reset.outSel",   32'(bus.out_sel),   32'h0);
    applyStimulus(5'b00000, 8'h10, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].valid, vecs[i].base, vecs[i].outReady);
      #1;
      checkOutput($sformatf("vec%0d.inReady", i), 32'(bus.in_ready), 32'(vecs[i].expReady));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d.outValid", i), 32'(bus.out_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d.outData", i),  32'(bus.out_data),  32'(vecs[i].expData));
      checkOutput($sformatf("vec%0d.outSel", i),   32'(bus.out_sel),   32'(vecs[i].expSel));
    end

    // Async reset between edges while FULL with out_sel=3.
    @(negedge clk);
    applyStimulus(5'b11111, 8'h10, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midReset.outValid", 32'(bus.out_valid), 32'h0);
    checkOutput("midReset.outData",  32'(bus.out_data),  32'h0);
    checkOutput("midReset.outSel",   32'(bus.out_sel),   32'h0);
    checkOutput("midReset.inReady",  32'(bus.in_ready),  32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("postReset.inReady", 32'(bus.in_ready), 32'h01);
    @(posedge clk);
    #1;
    checkOutput("postReset.outValid", 32'(bus.out_valid), 32'h1);
    checkOutput("postReset.outData",  32'(bus.out_data),  32'h10);
    checkOutput("postReset.outSel",   32'(bus.out_sel),   32'h0);
    @(negedge clk);
    #1;
    checkOutput("postReset2.inReady", 32'(bus.in_ready), 32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
